// File: rtl/vga_timing_if.sv
// VGA timing bundle: sync, blanking, raster position and frame/pixel strobes.
interface vga_timing_if;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       pix_tick;
    logic       frame_tick;
    logic [7:0] frame_count;

    modport master (
        output hSync, vSync, bright, hCount, vCount,
               pix_tick, frame_tick, frame_count
    );

    modport slave (
        input  hSync, vSync, bright, hCount, vCount,
               pix_tick, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A free-running divider produces a one-clk pixel enable; the column/line
// counters advance on that enable. Sync and blanking are decoded from the
// counters' next-state values and registered, so they line up with the
// registered counters in every cycle.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 514
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] H_VS_C  = 10'(H_VIS_START);
    localparam logic [9:0] H_VE_C  = 10'(H_VIS_END);
    localparam logic [9:0] V_VS_C  = 10'(V_VIS_START);
    localparam logic [9:0] V_VE_C  = 10'(V_VIS_END);

    logic [DIV_W-1:0] div_q;
    logic             pix_tick_q;
    logic [9:0]       h_q, v_q;
    logic [9:0]       h_nxt, v_nxt;
    logic             h_wrap, v_wrap;
    logic             hsync_q, vsync_q, bright_q;
    logic             frame_tick_q;
    logic [7:0]       frame_cnt_q;

    // Pixel enable: divider wraps at CLK_DIV-1, tick registered off its terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            pix_tick_q <= 1'b0;
        end else begin
            div_q      <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            pix_tick_q <= (div_q == DIV_LAST);
        end
    end

    // Next raster position; >= guards keep the counters inside their range
    always_comb begin
        h_wrap = (h_q >= H_LAST);
        v_wrap = (v_q >= V_LAST);
        h_nxt  = h_q;
        v_nxt  = v_q;
        if (pix_tick_q) begin
            h_nxt = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap)
                v_nxt = v_wrap ? 10'd0 : v_q + 10'd1;
        end
    end

    // Counters plus sync/blank decoded from next state so they share the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            h_q      <= h_nxt;
            v_q      <= v_nxt;
            hsync_q  <= (h_nxt >= H_SYNC_C);
            vsync_q  <= (v_nxt >= V_SYNC_C);
            bright_q <= (h_nxt >= H_VS_C) && (h_nxt <= H_VE_C) &&
                        (v_nxt >= V_VS_C) && (v_nxt <= V_VE_C);
        end
    end

    // Frame strobe and frame counter fire on the edge that wraps both counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            frame_tick_q <= pix_tick_q && h_wrap && v_wrap;
            if (pix_tick_q && h_wrap && v_wrap)
                frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign vga.hSync       = hsync_q;
    assign vga.vSync       = vsync_q;
    assign vga.bright      = bright_q;
    assign vga.hCount      = h_q;
    assign vga.vCount      = v_q;
    assign vga.pix_tick    = pix_tick_q;
    assign vga.frame_tick  = frame_tick_q;
    assign vga.frame_count = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a shrunken raster (8x6 pixels, 4 clks/pixel)
// so that many frames, including the 256-frame counter wrap, fit in a short run.
// Expected outputs come from a closed-form model driven by the number of clock
// edges since reset release.
module tb_vga_timing_gen;
    localparam int D   = 4;
    localparam int HT  = 8;
    localparam int HS  = 2;
    localparam int HVS = 3;
    localparam int HVE = 6;
    localparam int VT  = 6;
    localparam int VS  = 2;
    localparam int VVS = 2;
    localparam int VVE = 4;
    localparam int FRAME_PIX = HT * VT;
    localparam int FRAME_CLK = FRAME_PIX * D;
    localparam int VIS_PIX   = (HVE - HVS + 1) * (VVE - VVS + 1);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vga_timing_if vif ();

    vga_timing_gen #(
        .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif.master)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     n      = 0;   // clock edges since reset release
    longint cyc    = 0;

    // per-line / per-frame statistics
    int     prev_h, prev_v, prev_vs;
    int     hs_low, vs_low, br_cnt;
    int     fh, fv, lh, lv;
    bit     have_line, have_frame, wrapped;
    int     ft_seen;
    longint last_ft;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // pixels advanced: first advance on edge D+1, then every D edges
    function automatic int pix(input int nn);
        return (nn >= 1) ? (nn - 1) / D : 0;
    endfunction

    task automatic clear_stats();
        prev_h = 0; prev_v = 0; prev_vs = 0;
        hs_low = 0; vs_low = 0; br_cnt = 0;
        fh = 0; fv = 0; lh = 0; lv = 0;
        have_line = 0; have_frame = 0; ft_seen = 0; last_ft = 0;
    endtask

    task automatic compare();
        int p, eh, ev;
        p  = pix(n);
        eh = p % HT;
        ev = (p / HT) % VT;
        chk("hCount", vif.hCount, eh);
        chk("vCount", vif.vCount, ev);
        chk("hSync", vif.hSync, (eh >= HS));
        chk("vSync", vif.vSync, (ev >= VS));
        chk("bright", vif.bright, (eh >= HVS && eh <= HVE && ev >= VVS && ev <= VVE));
        chk("pix_tick", vif.pix_tick, (n >= D && n % D == 0));
        chk("frame_tick", vif.frame_tick,
            (n > D && (n - 1) % D == 0 && p > 0 && p % FRAME_PIX == 0));
        chk("frame_count_model", vif.frame_count, (p / FRAME_PIX) % 256);
        if (reset) return;

        if (vif.hCount == 0 && prev_h == HT - 1) begin
            chk("line_wrap_v", vif.vCount, (prev_v + 1) % VT);
            if (have_line) chk("hsync_low_clks", hs_low, HS * D);
            have_line = 1;
            hs_low = 0;
        end
        if (vif.frame_tick) begin
            ft_seen++;
            chk("frame_count", vif.frame_count, ft_seen % 256);
            if (ft_seen % 256 == 0) wrapped = 1;
            if (have_frame) begin
                chk("frame_period", 32'(cyc - last_ft), FRAME_CLK);
                chk("bright_pixels", br_cnt, VIS_PIX);
                chk("vsync_low_clks", vs_low, VS * HT * D);
                chk("first_bright_h", fh, HVS);
                chk("first_bright_v", fv, VVS);
                chk("last_bright_h", lh, HVE);
                chk("last_bright_v", lv, VVE);
            end
            have_frame = 1;
            last_ft = cyc;
            br_cnt = 0;
            vs_low = 0;
        end
        if (prev_vs == 1 && vif.vSync == 1'b0) chk("vsync_start_v", vif.vCount, 0);
        if (!vif.hSync) hs_low++;
        if (!vif.vSync) vs_low++;
        if (vif.pix_tick && vif.bright) begin
            if (br_cnt == 0) begin fh = vif.hCount; fv = vif.vCount; end
            lh = vif.hCount;
            lv = vif.vCount;
            br_cnt++;
        end
        prev_h  = vif.hCount;
        prev_v  = vif.vCount;
        prev_vs = vif.vSync;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!reset) n++;
        #1;
        compare();
    endtask

    // Called just after a step: asserts reset between edges, holds it for clks edges
    task automatic do_reset(input int clks);
        #2;
        reset = 1'b1;
        n = 0;
        clear_stats();
        #1;
        chk("async_rst_h", vif.hCount, 0);
        chk("async_rst_pt", vif.pix_tick, 0);
        compare();
        repeat (clks) step();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // First pixel tick after D edges, first column advance on the next edge
    task automatic release_check();
        for (int i = 1; i <= D + 1; i++) begin
            step();
            if (i == D)     chk("first_pix_tick", vif.pix_tick, 1);
            if (i == D + 1) chk("first_h_inc", vif.hCount, 1);
        end
    endtask

    initial begin
        bit found;
        clear_stats();
        wrapped = 0;

        // async reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_hSync", vif.hSync, 0);
        chk("rst_frame_count", vif.frame_count, 0);
        compare();
        repeat (3) step();
        @(negedge clk);
        reset = 1'b0;
        release_check();

        // a few frames of free running
        repeat (3 * FRAME_CLK) step();

        // reset mid-frame at a fixed raster position
        found = 0;
        for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
            step();
            if (pix(n) % HT == 5 && (pix(n) / HT) % VT == 3) found = 1;
        end
        chk("reach_5_3", found, 1);
        do_reset(3);
        release_check();

        // random reset episodes
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(50, 3 * FRAME_CLK)) step();
            do_reset($urandom_range(1, 4));
            release_check();
        end

        // long run across the 256-frame counter wrap
        repeat (257 * FRAME_CLK) step();
        chk("frame_count_wrapped", wrapped, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
